// File: rtl/avl_pkg.sv
// avl_pkg: shared widths, client IDs and the command record used by avl_arbiter.
package avl_pkg;

  localparam int AVL_ADDR_W = 26;
  localparam int AVL_DATA_W = 128;

  // Fixed client numbering of the mem_control requesters.
  typedef enum logic [1:0] {
    CL_RB1 = 2'd0,
    CL_RB2 = 2'd1,
    CL_MB  = 2'd2,
    CL_WBA = 2'd3
  } client_id_e;

  // One single-beat command as held in the DDR3-side command register.
  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [AVL_ADDR_W-1:0] addr;
    logic [AVL_DATA_W-1:0] wdata;
  } avl_cmd_t;

endpackage

// File: rtl/avl_arbiter_if.sv
// avl_arbiter_if: client-side request/return bus plus the DDR3 Avalon port.
// The slave modport is the arbiter's view; master is the clients/controller view.
interface avl_arbiter_if #(
  parameter int NUM_CLIENTS = 4
);
  import avl_pkg::*;

  logic [NUM_CLIENTS-1:0]                 cl_read;
  logic [NUM_CLIENTS-1:0]                 cl_write;
  logic [NUM_CLIENTS-1:0][AVL_ADDR_W-1:0] cl_address;
  logic [NUM_CLIENTS-1:0][AVL_DATA_W-1:0] cl_writedata;
  logic [NUM_CLIENTS-1:0]                 cl_wait_request_n;
  logic [AVL_DATA_W-1:0]                  cl_readdata;
  logic [NUM_CLIENTS-1:0]                 cl_readdatavalid;

  logic                  avl_burstbegin;
  logic                  avl_wait_request_n;
  logic [AVL_ADDR_W-1:0] avl_address;
  logic [AVL_DATA_W-1:0] avl_writedata;
  logic                  avl_write;
  logic                  avl_read;
  logic [AVL_DATA_W-1:0] avl_readdata;
  logic                  avl_readdatavalid;

  modport slave (
    input  cl_read, cl_write, cl_address, cl_writedata,
    input  avl_wait_request_n, avl_readdata, avl_readdatavalid,
    output cl_wait_request_n, cl_readdata, cl_readdatavalid,
    output avl_burstbegin, avl_address, avl_writedata, avl_write, avl_read
  );

  modport master (
    output cl_read, cl_write, cl_address, cl_writedata,
    output avl_wait_request_n, avl_readdata, avl_readdatavalid,
    input  cl_wait_request_n, cl_readdata, cl_readdatavalid,
    input  avl_burstbegin, avl_address, avl_writedata, avl_write, avl_read
  );

endinterface

// File: rtl/tag_fifo.sv
// tag_fifo: in-order FIFO of client IDs for reads that are still in flight.
// A pop on empty and a push on full (without a same-cycle pop) are ignored.
module tag_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [ID_W-1:0]        push_id,
  input  logic                   pop,
  output logic [ID_W-1:0]        head_id,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_id = mem[rd_ptr];

  // Tag storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avl_arbiter.sv
// avl_arbiter: round-robin arbiter funnelling the mem_control clients onto the
// single DDR3 Avalon port, routing each read return back to its requester.
// Note: the port named reset is active-low (low = in reset).
module avl_arbiter #(
  parameter int NUM_CLIENTS     = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic         iCLK,
  input  logic         reset,
  avl_arbiter_if.slave bus,
  output logic         err
);
  import avl_pkg::*;

  localparam int ID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        head_id;
  logic                   grant;
  logic                   can_load;
  logic                   rd_room;
  logic                   grant_rd;
  logic                   grant_wr;
  logic                   grant_both;
  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] grant_vec;
  logic [NUM_CLIENTS-1:0] return_vec;
  logic                   cmd_valid;
  logic                   burst;
  avl_cmd_t               cmd;
  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       fifo_count;
  logic                   unused_fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   underflow;
  logic [AVL_DATA_W-1:0]  rdata_q;
  logic [NUM_CLIENTS-1:0] rvalid_q;

  // The register may take a new command when empty or when the controller
  // accepts the current one; nothing is granted while reset is held.
  assign can_load   = reset && (!cmd_valid || bus.avl_wait_request_n);
  assign rd_room    = (outstanding < MAX_CNT) && !fifo_full;
  assign grant_wr   = grant && bus.cl_write[winner];
  assign grant_rd   = grant && bus.cl_read[winner] && !bus.cl_write[winner];
  assign grant_both = grant && bus.cl_read[winner] && bus.cl_write[winner];
  assign pop        = bus.avl_readdatavalid && !fifo_empty;
  assign underflow  = bus.avl_readdatavalid && fifo_empty;

  // The FIFO occupancy mirrors outstanding; it is kept only for debug probing.
  assign unused_fifo_count = ^fifo_count;

  // Writes are always eligible; reads only while there is room to track them.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      eligible[i] = bus.cl_write[i] || (bus.cl_read[i] && rd_room);
  end

  // Round-robin search starting at rr_ptr, wrapping around the client list.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_CLIENTS);
      if (can_load && !grant && eligible[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
  end

  // One-hot accept strobe to the winner and one-hot return strobe decode.
  always_comb begin
    grant_vec  = '0;
    return_vec = '0;
    if (grant) grant_vec[winner] = 1'b1;
    if (pop)   return_vec[head_id] = 1'b1;
  end

  // Command register: load on grant, drop after acceptance, hold under stall.
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset) begin
      cmd_valid <= 1'b0;
      burst     <= 1'b0;
      cmd       <= '0;
    end else if (can_load) begin
      if (grant) begin
        cmd_valid <= 1'b1;
        burst     <= 1'b1;
        cmd.rd    <= grant_rd;
        cmd.wr    <= grant_wr;
        cmd.addr  <= bus.cl_address[winner];
        cmd.wdata <= bus.cl_writedata[winner];
      end else begin
        cmd_valid <= 1'b0;
        burst     <= 1'b0;
        cmd.rd    <= 1'b0;
        cmd.wr    <= 1'b0;
      end
    end else begin
      burst <= 1'b0;
    end
  end

  // Advance the round-robin pointer past each winner.
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (grant)
      rr_ptr <= (winner == ID_W'(NUM_CLIENTS - 1)) ? '0 : winner + ID_W'(1);
  end

  // Reads in flight, counted from grant until their data beat returns.
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({grant_rd, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Register each return beat and strobe the client at the FIFO head.
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= return_vec;
      if (pop) rdata_q <= bus.avl_readdata;
    end
  end

  // Sticky error: read+write from one client, or a return with nothing pending.
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (grant_both || underflow)
      err <= 1'b1;
  end

  tag_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (iCLK),
    .rst_n   (reset),
    .push    (grant_rd),
    .push_id (winner),
    .pop     (pop),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign bus.cl_wait_request_n = grant_vec;
  assign bus.cl_readdata       = rdata_q;
  assign bus.cl_readdatavalid  = rvalid_q;
  assign bus.avl_burstbegin    = burst;
  assign bus.avl_address       = cmd.addr;
  assign bus.avl_writedata     = cmd.wdata;
  assign bus.avl_write         = cmd_valid && cmd.wr;
  assign bus.avl_read          = cmd_valid && cmd.rd;

endmodule

// File: tb/tb_avl_arbiter.sv
// tb_avl_arbiter: directed scenarios for avl_arbiter with hand-computed results.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_avl_arbiter;
  import avl_pkg::*;

  logic iCLK = 1'b0;
  logic reset;
  logic err;
  int   test_count = 0;
  int   fail_count = 0;

  avl_arbiter_if #(.NUM_CLIENTS(4)) bus ();

  avl_arbiter #(
    .NUM_CLIENTS     (4),
    .MAX_OUTSTANDING (16)
  ) dut (
    .iCLK  (iCLK),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  always #5 iCLK = ~iCLK;

  task automatic idle_inputs();
    bus.cl_read            = '0;
    bus.cl_write           = '0;
    bus.cl_address         = '0;
    bus.cl_writedata       = '0;
    bus.avl_wait_request_n = 1'b1;
    bus.avl_readdata       = '0;
    bus.avl_readdatavalid  = 1'b0;
  endtask

  // Leaves the caller on a falling edge with reset just released.
  task automatic reset_dut();
    @(negedge iCLK);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge iCLK);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2 reset = 1'b0;
    repeat (2) @(negedge iCLK);
    bus.cl_read[1] = 1'b1;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0000) begin fail_count++; $display("[TB] FAIL reset_grant: got %b expected 0000", bus.cl_wait_request_n); end
    test_count++; if (bus.avl_read !== 1'b0 || bus.avl_write !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_cmd: got rd=%b wr=%b expected 0 0", bus.avl_read, bus.avl_write); end
    test_count++; if (bus.avl_burstbegin !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_burst: got %b expected 0", bus.avl_burstbegin); end
    test_count++; if (bus.avl_address !== 26'h0) begin fail_count++; $display("[TB] FAIL reset_addr: got %h expected 0", bus.avl_address); end
    test_count++; if (bus.cl_readdatavalid !== 4'b0000 || bus.cl_readdata !== 128'h0) begin fail_count++; $display("[TB] FAIL reset_return: got %b/%h expected 0000/0", bus.cl_readdatavalid, bus.cl_readdata); end
    test_count++; if (err !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    bus.cl_read[1] = 1'b0;
    @(negedge iCLK);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    logic [127:0] rdata;
    rdata = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
    reset_dut();
    bus.cl_read[2]    = 1'b1;
    bus.cl_address[2] = 26'h0001234;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0100) begin fail_count++; $display("[TB] FAIL single_grant: got %b expected 0100", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_read[2]        = 1'b0;
    bus.avl_readdatavalid = 1'b1;
    bus.avl_readdata      = rdata;
    #1;
    test_count++; if (bus.avl_read !== 1'b1 || bus.avl_write !== 1'b0 || bus.avl_burstbegin !== 1'b1) begin fail_count++; $display("[TB] FAIL single_issue: got rd=%b wr=%b bb=%b expected 1 0 1", bus.avl_read, bus.avl_write, bus.avl_burstbegin); end
    test_count++; if (bus.avl_address !== 26'h0001234) begin fail_count++; $display("[TB] FAIL single_addr: got %h expected 0001234", bus.avl_address); end
    test_count++; if (bus.cl_readdatavalid !== 4'b0000) begin fail_count++; $display("[TB] FAIL single_early_rv: got %b expected 0000", bus.cl_readdatavalid); end
    @(negedge iCLK);
    bus.avl_readdatavalid = 1'b0;
    #1;
    test_count++; if (bus.cl_readdatavalid !== 4'b0100) begin fail_count++; $display("[TB] FAIL single_rv: got %b expected 0100", bus.cl_readdatavalid); end
    test_count++; if (bus.cl_readdata !== rdata) begin fail_count++; $display("[TB] FAIL single_rdata: got %h expected %h", bus.cl_readdata, rdata); end
    test_count++; if (bus.avl_read !== 1'b0) begin fail_count++; $display("[TB] FAIL single_cmd_drop: got %b expected 0", bus.avl_read); end
    @(negedge iCLK);
    #1;
    test_count++; if (bus.cl_readdatavalid !== 4'b0000) begin fail_count++; $display("[TB] FAIL single_rv_pulse: got %b expected 0000", bus.cl_readdatavalid); end
  endtask

  task automatic test_rotation();
    logic [25:0]  addr_tab [4];
    logic [127:0] data_tab [4];
    logic [3:0]   exp_gnt;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      addr_tab[i] = 26'h0ABC000 + 26'(i * 3);
      data_tab[i] = {32'hC0DE0000 + 32'(i), 96'h5A5A};
      bus.cl_write[i]     = 1'b1;
      bus.cl_address[i]   = addr_tab[i];
      bus.cl_writedata[i] = data_tab[i];
    end
    for (int k = 0; k < 9; k++) begin
      #1;
      exp_gnt = 4'(1 << (k % 4));
      test_count++; if (bus.cl_wait_request_n !== exp_gnt) begin fail_count++; $display("[TB] FAIL rot_grant[%0d]: got %b expected %b", k, bus.cl_wait_request_n, exp_gnt); end
      if (k > 0) begin
        test_count++;
        if (bus.avl_write !== 1'b1 || bus.avl_burstbegin !== 1'b1 || bus.avl_address !== addr_tab[(k-1)%4] || bus.avl_writedata !== data_tab[(k-1)%4]) begin
          fail_count++;
          $display("[TB] FAIL rot_cmd[%0d]: got wr=%b bb=%b addr=%h data=%h expected 1 1 %h %h", k, bus.avl_write, bus.avl_burstbegin, bus.avl_address, bus.avl_writedata, addr_tab[(k-1)%4], data_tab[(k-1)%4]);
        end
      end
      @(negedge iCLK);
    end
    bus.cl_write = '0;
  endtask

  task automatic test_stall();
    logic exp_bb;
    reset_dut();
    bus.cl_write[1]     = 1'b1;
    bus.cl_address[1]   = 26'h0002A5A;
    bus.cl_writedata[1] = 128'h1111;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0010) begin fail_count++; $display("[TB] FAIL stall_grant: got %b expected 0010", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_write[1]        = 1'b0;
    bus.cl_write[3]        = 1'b1;
    bus.cl_address[3]      = 26'h0003C3C;
    bus.avl_wait_request_n = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      exp_bb = (s == 0);
      test_count++;
      if (bus.avl_write !== 1'b1 || bus.avl_address !== 26'h0002A5A || bus.avl_burstbegin !== exp_bb || bus.cl_wait_request_n !== 4'b0000) begin
        fail_count++;
        $display("[TB] FAIL stall_hold[%0d]: got wr=%b addr=%h bb=%b gnt=%b expected 1 0002a5a %b 0000", s, bus.avl_write, bus.avl_address, bus.avl_burstbegin, bus.cl_wait_request_n, exp_bb);
      end
      @(negedge iCLK);
    end
    bus.avl_wait_request_n = 1'b1;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b1000) begin fail_count++; $display("[TB] FAIL stall_release_grant: got %b expected 1000", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_write[3] = 1'b0;
    #1;
    test_count++; if (bus.avl_address !== 26'h0003C3C || bus.avl_burstbegin !== 1'b1) begin fail_count++; $display("[TB] FAIL stall_next_cmd: got addr=%h bb=%b expected 0003c3c 1", bus.avl_address, bus.avl_burstbegin); end
  endtask

  task automatic test_outstanding();
    reset_dut();
    bus.cl_read[0]    = 1'b1;
    bus.cl_address[0] = 26'h0000100;
    for (int k = 0; k < 16; k++) begin
      #1;
      test_count++; if (bus.cl_wait_request_n !== 4'b0001) begin fail_count++; $display("[TB] FAIL out_fill[%0d]: got %b expected 0001", k, bus.cl_wait_request_n); end
      @(negedge iCLK);
    end
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0000) begin fail_count++; $display("[TB] FAIL out_block: got %b expected 0000", bus.cl_wait_request_n); end
    bus.cl_write[2]   = 1'b1;
    bus.cl_address[2] = 26'h0000222;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0100) begin fail_count++; $display("[TB] FAIL out_write_pass: got %b expected 0100", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_write[2]       = 1'b0;
    bus.avl_readdatavalid = 1'b1;
    bus.avl_readdata      = 128'hABCD;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0000 || bus.avl_write !== 1'b1) begin fail_count++; $display("[TB] FAIL out_still_block: got gnt=%b wr=%b expected 0000 1", bus.cl_wait_request_n, bus.avl_write); end
    @(negedge iCLK);
    bus.avl_readdatavalid = 1'b0;
    #1;
    test_count++; if (bus.cl_readdatavalid !== 4'b0001) begin fail_count++; $display("[TB] FAIL out_return: got %b expected 0001", bus.cl_readdatavalid); end
    test_count++; if (bus.cl_wait_request_n !== 4'b0001) begin fail_count++; $display("[TB] FAIL out_17th_grant: got %b expected 0001", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_read[0] = 1'b0;
    #1;
    test_count++; if (bus.avl_read !== 1'b1 || dut.outstanding !== 5'd16) begin fail_count++; $display("[TB] FAIL out_17th_issue: got rd=%b cnt=%0d expected 1 16", bus.avl_read, dut.outstanding); end
  endtask

  task automatic test_interleave();
    reset_dut();
    bus.cl_read[0] = 1'b1;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0001) begin fail_count++; $display("[TB] FAIL il_grant0: got %b expected 0001", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_read[0] = 1'b0;
    bus.cl_read[3] = 1'b1;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b1000) begin fail_count++; $display("[TB] FAIL il_grant3: got %b expected 1000", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_read[3]        = 1'b0;
    bus.cl_read[1]        = 1'b1;
    bus.avl_readdatavalid = 1'b1;
    bus.avl_readdata      = 128'hD0;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0010) begin fail_count++; $display("[TB] FAIL il_grant1: got %b expected 0010", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_read[1]   = 1'b0;
    bus.avl_readdata = 128'hD3;
    #1;
    test_count++; if (bus.cl_readdatavalid !== 4'b0001 || bus.cl_readdata !== 128'hD0) begin fail_count++; $display("[TB] FAIL il_ret0: got %b/%h expected 0001/d0", bus.cl_readdatavalid, bus.cl_readdata); end
    test_count++; if (dut.outstanding !== 5'd2) begin fail_count++; $display("[TB] FAIL il_cnt_pushpop: got %0d expected 2", dut.outstanding); end
    @(negedge iCLK);
    bus.avl_readdata = 128'hD1;
    #1;
    test_count++; if (bus.cl_readdatavalid !== 4'b1000 || bus.cl_readdata !== 128'hD3) begin fail_count++; $display("[TB] FAIL il_ret3: got %b/%h expected 1000/d3", bus.cl_readdatavalid, bus.cl_readdata); end
    @(negedge iCLK);
    bus.avl_readdatavalid = 1'b0;
    #1;
    test_count++; if (bus.cl_readdatavalid !== 4'b0010 || bus.cl_readdata !== 128'hD1) begin fail_count++; $display("[TB] FAIL il_ret1: got %b/%h expected 0010/d1", bus.cl_readdatavalid, bus.cl_readdata); end
    test_count++; if (dut.outstanding !== 5'd0 || err !== 1'b0) begin fail_count++; $display("[TB] FAIL il_drained: got cnt=%0d err=%b expected 0 0", dut.outstanding, err); end
  endtask

  task automatic test_errors();
    reset_dut();
    bus.avl_readdatavalid = 1'b1;
    bus.avl_readdata      = 128'hBAD;
    @(negedge iCLK);
    bus.avl_readdatavalid = 1'b0;
    #1;
    test_count++; if (err !== 1'b1 || bus.cl_readdatavalid !== 4'b0000) begin fail_count++; $display("[TB] FAIL err_underflow: got err=%b rv=%b expected 1 0000", err, bus.cl_readdatavalid); end
    reset_dut();
    #1;
    test_count++; if (err !== 1'b0) begin fail_count++; $display("[TB] FAIL err_reset_clear1: got %b expected 0", err); end
    bus.cl_read[1]      = 1'b1;
    bus.cl_write[1]     = 1'b1;
    bus.cl_address[1]   = 26'h0000777;
    bus.cl_writedata[1] = 128'h7777;
    #1;
    test_count++; if (bus.cl_wait_request_n !== 4'b0010) begin fail_count++; $display("[TB] FAIL err_rw_grant: got %b expected 0010", bus.cl_wait_request_n); end
    @(negedge iCLK);
    bus.cl_read[1]  = 1'b0;
    bus.cl_write[1] = 1'b0;
    #1;
    test_count++; if (bus.avl_write !== 1'b1 || bus.avl_read !== 1'b0 || bus.avl_writedata !== 128'h7777) begin fail_count++; $display("[TB] FAIL err_rw_issue: got wr=%b rd=%b data=%h expected 1 0 7777", bus.avl_write, bus.avl_read, bus.avl_writedata); end
    test_count++; if (err !== 1'b1 || dut.outstanding !== 5'd0) begin fail_count++; $display("[TB] FAIL err_rw_flag: got err=%b cnt=%0d expected 1 0", err, dut.outstanding); end
    reset_dut();
    #1;
    test_count++; if (err !== 1'b0) begin fail_count++; $display("[TB] FAIL err_reset_clear2: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.cl_read[0] = 1'b1;
    @(negedge iCLK);
    bus.cl_read[0] = 1'b0;
    #1;
    test_count++; if (bus.avl_read !== 1'b1) begin fail_count++; $display("[TB] FAIL mid_issue: got %b expected 1", bus.avl_read); end
    reset_dut();
    #1;
    test_count++; if (bus.avl_read !== 1'b0 || dut.outstanding !== 5'd0) begin fail_count++; $display("[TB] FAIL mid_cleared: got rd=%b cnt=%0d expected 0 0", bus.avl_read, dut.outstanding); end
    bus.avl_readdatavalid = 1'b1;
    @(negedge iCLK);
    bus.avl_readdatavalid = 1'b0;
    #1;
    test_count++; if (err !== 1'b1 || bus.cl_readdatavalid !== 4'b0000) begin fail_count++; $display("[TB] FAIL mid_stale_return: got err=%b rv=%b expected 1 0000", err, bus.cl_readdatavalid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rotation();
    test_stall();
    test_outstanding();
    test_interleave();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
